// File: rtl/foc_sequencer.sv
// rtl/foc_sequencer.sv - control sequencer in front of the FOC datapath
//
// Purpose: keeps shadow d/q PID coefficients and streams them into the PID
// write ports after reset and on commit. Turns sample_tick into a one-cycle
// valid request with registered samples. Counts dropped ticks and runs a
// watchdog while waiting for datapath completion.
//
// Ports:
//   clk, rstb                 clock, asynchronous active-high reset
//   cfg_we/sel/addr/data      shadow coefficient write (sel 0 = d, 1 = q)
//   cfg_commit                reload shadow coefficients into the datapath
//   sample_tick               control-period trigger
//   angle_s, currA_s, currB_s raw samples
//   angle_in, currA_in, currB_in, valid   request to the datapath
//   ready                     datapath completion level
//   pid_{d,q}_{wen,addr,data} coefficient write ports (wen active-low)
//   busy, cfg_done, overrun_cnt, timeout_err   status
module foc_sequencer #(
   parameter int D_WIDTH = 16,
   parameter int N_COEF  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               cfg_we,
   input  logic               cfg_sel,
   input  logic [1:0]         cfg_addr,
   input  logic [D_WIDTH-1:0] cfg_data,
   input  logic               cfg_commit,
   input  logic               sample_tick,
   input  logic [D_WIDTH-1:0] angle_s,
   input  logic [D_WIDTH-1:0] currA_s,
   input  logic [D_WIDTH-1:0] currB_s,
   output logic [D_WIDTH-1:0] angle_in,
   output logic [D_WIDTH-1:0] currA_in,
   output logic [D_WIDTH-1:0] currB_in,
   output logic               valid,
   input  logic               ready,
   output logic               pid_d_wen,
   output logic               pid_q_wen,
   output logic [D_WIDTH-1:0] pid_d_addr,
   output logic [D_WIDTH-1:0] pid_q_addr,
   output logic [D_WIDTH-1:0] pid_d_data,
   output logic [D_WIDTH-1:0] pid_q_data,
   output logic               busy,
   output logic               cfg_done,
   output logic [7:0]         overrun_cnt,
   output logic               timeout_err
);

   localparam int IW = $clog2(N_COEF + 1);
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_LOAD, S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t             state, state_nxt;
   logic [IW-1:0]      idx, idx_nxt;
   logic [WW-1:0]      wd, wd_nxt;
   logic               pend, pend_nxt;
   logic               ready_q;
   logic               wen_r, wen_nxt;
   logic [D_WIDTH-1:0] addr_r, addr_nxt;
   logic [D_WIDTH-1:0] dat_d, dat_d_nxt, dat_q, dat_q_nxt;
   logic               done_nxt, terr_nxt, take_tick;
   logic [7:0]         ovr_nxt;
   logic [D_WIDTH-1:0] cur_d, cur_q;
   logic [D_WIDTH-1:0] shadow_d [N_COEF];
   logic [D_WIDTH-1:0] shadow_q [N_COEF];

   logic commit_any, completion, wd_last, tick_drop;

   // A pending commit behaves like a live one at every decision point.
   assign commit_any = cfg_commit | pend;
   // Only a rising edge counts; ready_q is sampled in every state, so a
   // level already high when WAIT is entered does not complete.
   assign completion = ready & ~ready_q;
   assign wd_last    = (wd == WW'(TIMEOUT - 1));
   assign tick_drop  = sample_tick & ((state != S_IDLE) | commit_any);

   function automatic logic [D_WIDTH-1:0] coef_default(input int i);
      return (i == 0) ? D_WIDTH'(4096) : (i == 1) ? D_WIDTH'(512) : '0;
   endfunction

   // Shadow coefficients: writable in every state.
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         for (int i = 0; i < N_COEF; i++) begin
            shadow_d[i] <= coef_default(i);
            shadow_q[i] <= coef_default(i);
         end
      end else if (cfg_we) begin
         for (int i = 0; i < N_COEF; i++) begin
            if (cfg_addr == i[1:0]) begin
               if (cfg_sel) shadow_q[i] <= cfg_data;
               else         shadow_d[i] <= cfg_data;
            end
         end
      end
   end

   always_comb begin
      cur_d = '0;
      cur_q = '0;
      for (int i = 0; i < N_COEF; i++) begin
         if (idx == IW'(i)) begin
            cur_d = shadow_d[i];
            cur_q = shadow_q[i];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) state <= S_LOAD;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD:  if (idx == IW'(N_COEF)) state_nxt = S_IDLE;
         S_IDLE:  if (commit_any)         state_nxt = S_LOAD;
                  else if (sample_tick)   state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (completion)         state_nxt = commit_any ? S_LOAD : S_IDLE;
                  else if (wd_last)       state_nxt = S_IDLE;
         default: state_nxt = S_LOAD;
      endcase
   end

   // Output / datapath next-value logic
   always_comb begin
      wen_nxt   = 1'b1;
      addr_nxt  = addr_r;
      dat_d_nxt = dat_d;
      dat_q_nxt = dat_q;
      done_nxt  = 1'b0;
      idx_nxt   = idx;
      if (state == S_LOAD) begin
         if (idx == IW'(N_COEF)) begin
            done_nxt = 1'b1;
            idx_nxt  = '0;
         end else begin
            wen_nxt   = 1'b0;
            addr_nxt  = D_WIDTH'(idx);
            dat_d_nxt = cur_d;
            dat_q_nxt = cur_q;
            idx_nxt   = idx + IW'(1);
         end
      end
      take_tick = (state == S_IDLE) & ~commit_any & sample_tick;
      wd_nxt    = (state == S_WAIT) ? wd + WW'(1) : '0;
      terr_nxt  = timeout_err | ((state == S_WAIT) & ~completion & wd_last);
      ovr_nxt   = (tick_drop && overrun_cnt != 8'hFF) ? overrun_cnt + 8'd1 : overrun_cnt;
      // Entering LOAD consumes the commit; otherwise late commits accumulate.
      if (state_nxt == S_LOAD && state != S_LOAD) pend_nxt = 1'b0;
      else pend_nxt = pend | (cfg_commit & (state != S_IDLE));
   end

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         idx         <= '0;
         wd          <= '0;
         pend        <= 1'b0;
         ready_q     <= 1'b0;
         wen_r       <= 1'b1;
         addr_r      <= '0;
         dat_d       <= '0;
         dat_q       <= '0;
         cfg_done    <= 1'b0;
         overrun_cnt <= '0;
         timeout_err <= 1'b0;
         angle_in    <= '0;
         currA_in    <= '0;
         currB_in    <= '0;
      end else begin
         idx         <= idx_nxt;
         wd          <= wd_nxt;
         pend        <= pend_nxt;
         ready_q     <= ready;
         wen_r       <= wen_nxt;
         addr_r      <= addr_nxt;
         dat_d       <= dat_d_nxt;
         dat_q       <= dat_q_nxt;
         cfg_done    <= done_nxt;
         overrun_cnt <= ovr_nxt;
         timeout_err <= terr_nxt;
         if (take_tick) begin
            angle_in <= angle_s;
            currA_in <= currA_s;
            currB_in <= currB_s;
         end
      end
   end

   assign valid      = (state == S_ISSUE);
   assign busy       = (state != S_IDLE);
   assign pid_d_wen  = wen_r;
   assign pid_q_wen  = wen_r;
   assign pid_d_addr = addr_r;
   assign pid_q_addr = addr_r;
   assign pid_d_data = dat_d;
   assign pid_q_data = dat_q;

endmodule

// File: tb/tb_foc_sequencer.sv
// tb/tb_foc_sequencer.sv - directed self-checking bench for foc_sequencer
module tb_foc_sequencer;

   logic        clk = 1'b0;
   logic        rstb = 1'b1;
   logic        cfg_we = 1'b0, cfg_sel = 1'b0, cfg_commit = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic        sample_tick = 1'b0, ready = 1'b0;
   logic [15:0] angle_s = '0, currA_s = '0, currB_s = '0;
   logic [15:0] angle_in, currA_in, currB_in;
   logic        valid, pid_d_wen, pid_q_wen, busy, cfg_done, timeout_err;
   logic [15:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;
   logic [7:0]  overrun_cnt;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] DEF_COEF = {16'd0, 16'd0, 16'd512, 16'd4096};
   localparam logic [63:0] Q_COEF   = {16'd0, 16'd0, 16'd256, 16'd4096};

   foc_sequencer #(.D_WIDTH(16), .N_COEF(4), .TIMEOUT(1024)) dut (
      .clk(clk), .rstb(rstb),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .sample_tick(sample_tick),
      .angle_s(angle_s), .currA_s(currA_s), .currB_s(currB_s),
      .angle_in(angle_in), .currA_in(currA_in), .currB_in(currB_in),
      .valid(valid), .ready(ready),
      .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
      .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr),
      .pid_d_data(pid_d_data), .pid_q_data(pid_q_data),
      .busy(busy), .cfg_done(cfg_done), .overrun_cnt(overrun_cnt),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called one negedge before the first LOAD edge.
   task automatic check_load(input string tag, input logic [63:0] dv, input logic [63:0] qv);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk({tag, " d_wen"}, 32'(pid_d_wen), 32'd0);
         chk({tag, " q_wen"}, 32'(pid_q_wen), 32'd0);
         chk({tag, " d_addr"}, 32'(pid_d_addr), 32'(k));
         chk({tag, " q_addr"}, 32'(pid_q_addr), 32'(k));
         chk({tag, " d_data"}, 32'(pid_d_data), 32'(dv[16*k +: 16]));
         chk({tag, " q_data"}, 32'(pid_q_data), 32'(qv[16*k +: 16]));
         chk({tag, " valid"}, 32'(valid), 32'd0);
      end
      @(negedge clk);
      chk({tag, " wen_end"}, 32'({pid_d_wen, pid_q_wen}), 32'd3);
      chk({tag, " cfg_done"}, 32'(cfg_done), 32'd1);
      chk({tag, " busy_end"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, " cfg_done_pulse"}, 32'(cfg_done), 32'd0);
   endtask

   task automatic accept_tick(input logic [15:0] a, input logic [15:0] ca, input logic [15:0] cb);
      angle_s = a; currA_s = ca; currB_s = cb;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      angle_s = 16'h5555; currA_s = 16'h6666; currB_s = 16'h7777;
      chk("issue valid", 32'(valid), 32'd1);
      chk("issue angle", 32'(angle_in), 32'(a));
      chk("issue currA", 32'(currA_in), 32'(ca));
      chk("issue currB", 32'(currB_in), 32'(cb));
      @(negedge clk);
      chk("wait valid", 32'(valid), 32'd0);
      chk("wait busy", 32'(busy), 32'd1);
      chk("wait hold angle", 32'(angle_in), 32'(a));
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst valid", 32'(valid), 32'd0);
      chk("rst wen", 32'({pid_d_wen, pid_q_wen}), 32'd3);
      chk("rst addr", 32'({pid_d_addr, pid_q_addr}), 32'd0);
      chk("rst data", 32'({pid_d_data, pid_q_data}), 32'd0);
      chk("rst busy", 32'(busy), 32'd1);
      chk("rst cfg_done", 32'(cfg_done), 32'd0);
      chk("rst overrun", 32'(overrun_cnt), 32'd0);
      chk("rst timeout", 32'(timeout_err), 32'd0);
      chk("rst angle", 32'(angle_in), 32'd0);
      rstb = 1'b0;
      check_load("load0", DEF_COEF, DEF_COEF);

      // Tick in IDLE, ready 20 cycles later
      accept_tick(16'h1FFF, 16'h1000, 16'hF000);
      repeat (18) @(negedge clk);
      chk("t2 still busy", 32'(busy), 32'd1);
      chk("t2 hold currB", 32'(currB_in), 32'hF000);
      pulse_ready();
      chk("t2 idle", 32'(busy), 32'd0);

      // Overruns and commit in WAIT
      accept_tick(16'h0123, 16'h0456, 16'h0789);
      repeat (3) begin
         sample_tick = 1'b1;
         @(negedge clk);
         sample_tick = 1'b0;
         @(negedge clk);
      end
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 2'd1; cfg_data = 16'd256;
      @(negedge clk);
      cfg_we = 1'b0; cfg_commit = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
      chk("t3 overrun", 32'(overrun_cnt), 32'd3);
      chk("t3 busy wait", 32'(busy), 32'd1);
      pulse_ready();
      chk("t3 busy load", 32'(busy), 32'd1);
      check_load("load1", DEF_COEF, Q_COEF);

      // Commit and tick together in IDLE
      cfg_commit = 1'b1; sample_tick = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0; sample_tick = 1'b0;
      chk("t5 valid", 32'(valid), 32'd0);
      chk("t5 busy", 32'(busy), 32'd1);
      chk("t5 overrun", 32'(overrun_cnt), 32'd4);
      check_load("load2", DEF_COEF, Q_COEF);

      // Watchdog with 300 dropped ticks inside the wait window
      accept_tick(16'h2222, 16'h3333, 16'h4444);
      for (int i = 0; i < 1023; i++) begin
         @(negedge clk);
         sample_tick = (i < 600) && (i % 2 == 0);
      end
      chk("t4 overrun sat", 32'(overrun_cnt), 32'd255);
      chk("t4 no timeout yet", 32'(timeout_err), 32'd0);
      chk("t4 busy before", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t4 timeout", 32'(timeout_err), 32'd1);
      chk("t4 idle", 32'(busy), 32'd0);
      accept_tick(16'hABCD, 16'h00EF, 16'h8001);
      chk("t4 sticky", 32'(timeout_err), 32'd1);
      pulse_ready();
      chk("t4 back idle", 32'(busy), 32'd0);

      // Reset asserted during WAIT
      accept_tick(16'h0F0F, 16'h1111, 16'h2222);
      repeat (3) @(negedge clk);
      #2 rstb = 1'b1;
      #1;
      chk("arst timeout", 32'(timeout_err), 32'd0);
      chk("arst overrun", 32'(overrun_cnt), 32'd0);
      chk("arst angle", 32'(angle_in), 32'd0);
      chk("arst currA", 32'(currA_in), 32'd0);
      chk("arst wen", 32'({pid_d_wen, pid_q_wen}), 32'd3);
      chk("arst data", 32'({pid_d_data, pid_q_data}), 32'd0);
      chk("arst busy", 32'(busy), 32'd1);
      @(negedge clk);
      rstb = 1'b0;
      check_load("load3", DEF_COEF, DEF_COEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/foc_sequencer.md
Name: foc_sequencer

Overview:
Control sequencer in front of the FOC top-level datapath.
- Holds shadow copies of the d- and q-axis PID coefficients and streams them into the PID coefficient write ports after reset and on each commit.
- Converts a periodic sample_tick into a single-cycle valid request carrying registered angle/current samples.
- Tracks ready completion, counts overruns and flags a stalled datapath via watchdog.

Parameters:
D_WIDTH, 16, data width of samples, coefficients and PID address/data buses
N_COEF, 4, coefficients per axis (addresses 0..N_COEF-1)
TIMEOUT, 1024, max cycles in WAIT before watchdog abort

Ports:
clk  in  1  clock
rstb  in  1  reset, asynchronous, active-high
cfg_we  in  1  shadow coefficient write strobe
cfg_sel  in  1  axis select for cfg_we: 0 = d, 1 = q
cfg_addr  in  2  shadow coefficient index
cfg_data  in  D_WIDTH  shadow coefficient value
cfg_commit  in  1  request reload of shadow coefficients into datapath
sample_tick  in  1  one-cycle control-period trigger
angle_s  in  D_WIDTH  resolver angle sample
currA_s, currB_s  in  D_WIDTH each  phase current samples
angle_in, currA_in, currB_in  out  D_WIDTH each  registered samples to datapath
valid  out  1  request to datapath, one-cycle pulse
ready  in  1  datapath completion, level
pid_d_wen, pid_q_wen  out  1  coefficient write enable, active-low
pid_d_addr, pid_q_addr  out  D_WIDTH  coefficient address
pid_d_data, pid_q_data  out  D_WIDTH  coefficient data
busy  out  1  high in any state other than IDLE
cfg_done  out  1  one-cycle pulse when a LOAD completes
overrun_cnt  out  8  dropped sample_tick count, saturating at 255
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values (async):
  - valid=0, pid_*_wen=1, pid_*_addr=0, pid_*_data=0.
  - Sample outputs 0, cfg_done=0, overrun_cnt=0, timeout_err=0, busy=1.
  - State=LOAD, load index=0.
- Shadow reset values, both axes: coef0=4096 (1<<12), coef1=512 (1<<9), coef2=0, coef3=0.
- Shadow writes: cfg_we writes shadow[cfg_sel][cfg_addr] at the clock edge, in every state. A write during LOAD to an index not yet streamed is picked up in the current LOAD.
- States: LOAD, IDLE, ISSUE, WAIT.
- LOAD:
  - For k=0..N_COEF-1 on consecutive cycles: both wen=0, addr=k, data=shadow[d/q][k]. d and q stream in parallel.
  - The cycle after k=N_COEF-1: wen=1, cfg_done=1 for one cycle, go to IDLE.
  - LOAD starts on the first clk edge after rstb falls, so wen is low for exactly N_COEF cycles.
- IDLE:
  - cfg_commit=1 -> LOAD. Commit has priority; a coincident sample_tick is dropped and counted as overrun.
  - Else sample_tick=1 -> register angle_s, currA_s, currB_s onto the outputs at that edge, go to ISSUE.
- ISSUE: valid=1 for exactly this one cycle; sample outputs held stable; go to WAIT.
- WAIT:
  - Completion is a rising edge of ready (ready=1 and registered ready_q=0) -> IDLE. If a commit is pending, go to LOAD instead.
  - A ready level that is already high on WAIT entry is not completion.
  - Watchdog counter reaching TIMEOUT -> timeout_err=1, go to IDLE. The pending commit is still honoured on the next IDLE cycle.
- Samples: angle_in/currA_in/currB_in change only on tick acceptance and hold otherwise.
- Overrun: sample_tick in LOAD, ISSUE or WAIT is dropped; overrun_cnt++ (saturates at 255).
- cfg_commit in LOAD, ISSUE or WAIT sets a pending flag, consumed on the next return to IDLE/LOAD decision. Multiple commits collapse into one.
- Latency: tick in IDLE at edge N -> valid high during cycle N..N+1. Best-case tick-to-next-accept is 3 cycles plus the datapath ready latency.
- Reset mid-operation (any state): all state and counters return to reset values immediately, and LOAD restarts. Shadow registers reset to defaults; pending commit and timeout_err cleared.

Test Plan:
- Reset release -> pid_d/q_wen=0 for 4 cycles with addr 0,1,2,3 and data 4096,512,0,0; then wen=1, cfg_done pulse, busy=0.
- IDLE, sample_tick with angle_s=0x1FFF, currA_s=0x1000, currB_s=0xF000 -> next cycle valid=1 for one cycle with those values on outputs. Model ready rising 20 cycles later -> back to IDLE, busy=0.
- In WAIT: 3 sample_ticks, then cfg_we(sel=1,addr=1,data=256) and cfg_commit -> overrun_cnt=3. After ready, LOAD streams q data 4096,256,0,0 and d data unchanged.
- ready held low after valid -> timeout_err=1 exactly TIMEOUT cycles after WAIT entry, state IDLE; the next tick is accepted normally.
- cfg_commit and sample_tick in the same IDLE cycle -> LOAD entered, no valid, overrun_cnt+1. 300 dropped ticks -> overrun_cnt saturates at 255.
- Assert rstb during WAIT -> outputs return to reset values asynchronously; after release, full LOAD sequence repeats with default coefficients.
